// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between an instruction-fetch requester
//   and a load/store requester. One transaction is in flight at a time and
//   walks IDLE -> ISSUE -> WAIT (MEM_LATENCY cycles) -> RESP -> IDLE.
//   Ties are broken round-robin on a last-grant flag.
//
// Parameters
//   MEM_LATENCY : memory read latency in cycles, mem_en to valid mem_rdata (1..4)
//   WORD_ADDR   : 1 = mem_addr is a word address (byte addr >> 2), 0 = byte address
//
// Ports
//   aclk, areset                  clock, synchronous active-high reset
//   if_req/if_addr                fetch request and byte address
//   if_gnt/if_rvalid/if_rdata     fetch accept pulse, data-valid pulse, data
//   ls_req/ls_addr/ls_we/ls_wdata load/store request (ls_we == 0 means load)
//   ls_gnt/ls_rvalid/ls_rdata     load/store accept, done pulse, load data
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata           shared memory port
module mem_port_arbiter #(
   parameter int MEM_LATENCY = 1,
   parameter bit WORD_ADDR   = 1'b1
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        ls_req,
   input  logic [31:0] ls_addr,
   input  logic [3:0]  ls_we,
   input  logic [31:0] ls_wdata,
   output logic        ls_gnt,
   output logic        ls_rvalid,
   output logic [31:0] ls_rdata,
   output logic        mem_en,
   output logic [3:0]  mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   // WAIT counts down from MEM_LATENCY-1 to 0; the zero cycle captures data
   localparam logic [1:0] CNT_INIT = 2'(MEM_LATENCY - 1);

   logic [1:0]  state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        last_ls_q, last_ls_d;   // 1: load/store was granted last
   logic        win_ls_q, win_ls_d;     // owner of the in-flight transaction
   logic [31:0] addr_q, addr_d;
   logic [3:0]  we_q, we_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] ls_rdata_q, ls_rdata_d;

   logic        pick_ls;
   logic        in_issue, in_resp;
   logic [31:0] addr_map;
   logic        unused_addr_bits;

   // Load/store wins when it is the only requester, or on a tie when fetch
   // had the previous grant.
   assign pick_ls = ls_req && (!if_req || !last_ls_q);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_ls_d  = last_ls_q;
      win_ls_d   = win_ls_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      ls_rdata_d = ls_rdata_q;
      case (state_q)
         S_IDLE: begin
            if (if_req || ls_req) begin
               win_ls_d  = pick_ls;
               last_ls_d = pick_ls;
               addr_d    = pick_ls ? ls_addr : if_addr;
               // fetches are always reads
               we_d      = pick_ls ? ls_we : 4'h0;
               wdata_d   = pick_ls ? ls_wdata : 32'h0;
               state_d   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = CNT_INIT;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == 2'd0) begin
               if (win_ls_q) ls_rdata_d = (we_q == 4'h0) ? mem_rdata : 32'h0;
               else          if_rdata_d = mem_rdata;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         default: state_d = S_IDLE;   // S_RESP
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q    <= S_IDLE;
         cnt_q      <= 2'd0;
         last_ls_q  <= 1'b1;
         win_ls_q   <= 1'b0;
         addr_q     <= 32'h0;
         we_q       <= 4'h0;
         wdata_q    <= 32'h0;
         if_rdata_q <= 32'h0;
         ls_rdata_q <= 32'h0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_ls_q  <= last_ls_d;
         win_ls_q   <= win_ls_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         ls_rdata_q <= ls_rdata_d;
      end
   end

   assign in_issue = (state_q == S_ISSUE);
   assign in_resp  = (state_q == S_RESP);

   assign addr_map = WORD_ADDR ? {2'b00, addr_q[31:2]} : addr_q;
   // byte-offset bits are dropped in word-address mode
   assign unused_addr_bits = ^addr_q[1:0];

   // Memory port is quiet (all zero) outside the single ISSUE cycle.
   assign mem_en    = in_issue;
   assign mem_we    = in_issue ? we_q     : 4'h0;
   assign mem_addr  = in_issue ? addr_map : 32'h0;
   assign mem_wdata = in_issue ? wdata_q  : 32'h0;

   assign if_gnt    = in_issue && !win_ls_q;
   assign ls_gnt    = in_issue &&  win_ls_q;
   assign if_rvalid = in_resp  && !win_ls_q;
   assign ls_rvalid = in_resp  &&  win_ls_q;
   assign if_rdata  = if_rdata_q;
   assign ls_rdata  = ls_rdata_q;

endmodule
